filter_ctrl: RTL and testbench



---
 rtl/filter_ctrl_pkg.sv | 17 +
 rtl/filter_ctrl_if.sv | 34 +++
 rtl/inflight_cnt.sv | 30 +++
 rtl/filter_ctrl.sv | 118 +++++++++++
 tb/tb_filter_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the IIR filter sequencer/config controller.
package filter_ctrl_pkg;

    localparam int unsigned CFG_ADDR_W = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [CFG_ADDR_W-1:0] ADDR_A1     = 2'd0;
    localparam logic [CFG_ADDR_W-1:0] ADDR_B1     = 2'd1;
    localparam logic [CFG_ADDR_W-1:0] ADDR_B0     = 2'd2;
    localparam logic [CFG_ADDR_W-1:0] ADDR_COMMIT = 2'd3;

endpackage

// File: rtl/filter_ctrl_if.sv
// Sample source, filter and config port signals of filter_ctrl.
// master = controller side, slave = surrounding environment.
interface filter_ctrl_if #(
    parameter int unsigned NB = 11
) ();
    import filter_ctrl_pkg::*;

    logic [NB-1:0]         S_DIN;
    logic                  S_VIN;
    logic                  S_RDY;
    logic [NB-1:0]         F_DIN;
    logic                  F_VIN;
    logic                  F_VOUT;
    logic                  F_RST_n;
    logic [NB-1:0]         A1;
    logic [NB-1:0]         B1;
    logic [NB-1:0]         B0;
    logic                  CFG_WE;
    logic [CFG_ADDR_W-1:0] CFG_ADDR;
    logic [NB-1:0]         CFG_WDATA;
    logic                  CFG_BUSY;
    logic                  ERR;

    modport master (
        input  S_DIN, S_VIN, F_VOUT, CFG_WE, CFG_ADDR, CFG_WDATA,
        output S_RDY, F_DIN, F_VIN, F_RST_n, A1, B1, B0, CFG_BUSY, ERR
    );

    modport slave (
        output S_DIN, S_VIN, F_VOUT, CFG_WE, CFG_ADDR, CFG_WDATA,
        input  S_RDY, F_DIN, F_VIN, F_RST_n, A1, B1, B0, CFG_BUSY, ERR
    );

endinterface

// File: rtl/inflight_cnt.sv
// Up/down counter of samples inside the filter, saturating at LAT+1,
// with a combinational flag for a decrement seen while already empty.
module inflight_cnt #(
    parameter  int unsigned LAT = 2,
    localparam int unsigned W   = $clog2(LAT + 2)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         underflow_c
);

    localparam logic [W-1:0] MAXV = W'(LAT + 1);

    assign underflow_c = dec & ~inc & (count == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !dec && (count != MAXV)) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/filter_ctrl.sv
// Forwards samples to the IIR filter through one register stage and swaps
// shadow coefficients in atomically after stalling the source and draining.
module filter_ctrl #(
    parameter int unsigned NB         = 11,
    parameter int unsigned LAT        = 2,
    parameter int unsigned TMO        = 16,
    parameter bit          CLR_ON_UPD = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    filter_ctrl_if.master  bus
);
    import filter_ctrl_pkg::*;

    localparam int unsigned CNT_W = $clog2(LAT + 2);
    localparam int unsigned DRN_W = (TMO > 1) ? $clog2(TMO) : 1;

    state_t            state;
    logic [NB-1:0]     sh_a1;
    logic [NB-1:0]     sh_b1;
    logic [NB-1:0]     sh_b0;
    logic [DRN_W-1:0]  drain_cnt;
    logic [CNT_W-1:0]  inflight;
    logic              underflow_c;
    logic              accept_c;
    logic              drained_c;
    logic              timeout_c;
    logic              cnt_clr_c;

    assign bus.S_RDY    = (state == RUN) & ~RST;
    assign bus.CFG_BUSY = (state != RUN);
    // Filter reset follows RST, plus a one-cycle clear pulse during UPDATE.
    assign bus.F_RST_n  = ~RST & ~((state == UPDATE) & CLR_ON_UPD);

    assign accept_c  = bus.S_VIN & bus.S_RDY;
    assign drained_c = ~bus.F_VIN & (inflight == '0);
    assign timeout_c = (drain_cnt == DRN_W'(TMO - 1));
    assign cnt_clr_c = (state == DRAIN) & timeout_c & ~drained_c;

    inflight_cnt #(
        .LAT (LAT)
    ) u_inflight (
        .clk         (CLK),
        .rst         (RST),
        .clr         (cnt_clr_c),
        .inc         (bus.F_VIN),
        .dec         (bus.F_VOUT),
        .count       (inflight),
        .underflow_c (underflow_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            bus.F_VIN <= 1'b0;
            bus.F_DIN <= '0;
            bus.A1    <= '0;
            bus.B1    <= '0;
            bus.B0    <= '0;
            bus.ERR   <= 1'b0;
            sh_a1     <= '0;
            sh_b1     <= '0;
            sh_b0     <= '0;
            drain_cnt <= '0;
        end else begin
            bus.F_VIN <= accept_c;
            if (accept_c) begin
                bus.F_DIN <= bus.S_DIN;
            end
            if (underflow_c) begin
                bus.ERR <= 1'b1;
            end

            case (state)
                RUN: begin
                    if (bus.CFG_WE) begin
                        case (bus.CFG_ADDR)
                            ADDR_A1:     sh_a1 <= bus.CFG_WDATA;
                            ADDR_B1:     sh_b1 <= bus.CFG_WDATA;
                            ADDR_B0:     sh_b0 <= bus.CFG_WDATA;
                            ADDR_COMMIT: begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end
                        endcase
                    end
                end

                // Wait for the filter to empty; give up after TMO cycles.
                DRAIN: begin
                    if (bus.CFG_WE) begin
                        bus.ERR <= 1'b1;
                    end
                    drain_cnt <= drain_cnt + DRN_W'(1);
                    if (drained_c) begin
                        state <= UPDATE;
                    end else if (timeout_c) begin
                        state   <= UPDATE;
                        bus.ERR <= 1'b1;
                    end
                end

                UPDATE: begin
                    if (bus.CFG_WE) begin
                        bus.ERR <= 1'b1;
                    end
                    bus.A1 <= sh_a1;
                    bus.B1 <= sh_b1;
                    bus.B0 <= sh_b0;
                    state  <= RUN;
                end

                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_ctrl.sv
// Directed self-checking bench for filter_ctrl with a LAT-cycle filter stand-in.
module tb_filter_ctrl;
    import filter_ctrl_pkg::*;

    localparam int unsigned NB  = 11;
    localparam int unsigned LAT = 2;
    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst;
    logic vout_en;
    logic [LAT-1:0] vout_pipe;
    int checks = 0;
    int errors = 0;

    filter_ctrl_if #(.NB(NB)) bus ();

    filter_ctrl #(
        .NB         (NB),
        .LAT        (LAT),
        .TMO        (TMO),
        .CLR_ON_UPD (1'b1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Filter stand-in: VOUT follows VIN by LAT cycles, can be muted.
    always @(posedge clk) begin
        if (rst) vout_pipe <= '0;
        else     vout_pipe <= {vout_pipe[LAT-2:0], bus.F_VIN};
    end
    assign bus.F_VOUT = vout_en & vout_pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [NB-1:0] data);
        bus.CFG_WE    = 1'b1;
        bus.CFG_ADDR  = addr;
        bus.CFG_WDATA = data;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] samples [8];
        int stall, rst_low, early, busy;
        samples = '{11'h001, 11'h7FF, 11'h2AA, 11'h555, 11'h000, 11'h123, 11'h400, 11'h3C3};

        rst           = 1'b1;
        vout_en       = 1'b1;
        bus.S_DIN     = '0;
        bus.S_VIN     = 1'b0;
        bus.CFG_WE    = 1'b0;
        bus.CFG_ADDR  = '0;
        bus.CFG_WDATA = '0;
        tick();
        tick();

        // Reset values
        check_eq("rst_s_rdy",   32'(bus.S_RDY),    32'h0);
        check_eq("rst_f_rst_n", 32'(bus.F_RST_n),  32'h0);
        check_eq("rst_busy",    32'(bus.CFG_BUSY), 32'h0);
        check_eq("rst_err",     32'(bus.ERR),      32'h0);
        check_eq("rst_f_vin",   32'(bus.F_VIN),    32'h0);
        check_eq("rst_f_din",   32'(bus.F_DIN),    32'h0);
        check_eq("rst_a1",      32'(bus.A1),       32'h0);
        rst = 1'b0;
        tick();
        check_eq("run_s_rdy",   32'(bus.S_RDY),    32'h1);
        check_eq("run_f_rst_n", 32'(bus.F_RST_n),  32'h1);

        // Stream 8 samples, one-cycle forward latency
        for (int i = 0; i < 8; i++) begin
            bus.S_VIN = 1'b1;
            bus.S_DIN = samples[i];
            tick();
            check_eq("fwd_vin",   32'(bus.F_VIN), 32'h1);
            check_eq("fwd_din",   32'(bus.F_DIN), 32'(samples[i]));
            check_eq("fwd_s_rdy", 32'(bus.S_RDY), 32'h1);
        end
        bus.S_VIN = 1'b0;
        tick();
        check_eq("fwd_idle_vin", 32'(bus.F_VIN), 32'h0);
        check_eq("fwd_hold_din", 32'(bus.F_DIN), 32'h3C3);
        repeat (4) tick();
        check_eq("stream_err", 32'(bus.ERR), 32'h0);

        // Commit with samples in flight
        cfg_write(ADDR_A1, 11'h155);
        cfg_write(ADDR_B1, 11'h0AA);
        cfg_write(ADDR_B0, 11'h3FF);
        bus.CFG_WE = 1'b0;
        bus.S_VIN  = 1'b1;
        bus.S_DIN  = 11'h011;
        tick();
        bus.S_DIN  = 11'h022;
        tick();
        bus.S_DIN  = 11'h033;
        cfg_write(ADDR_COMMIT, '0);
        bus.S_VIN  = 1'b0;
        bus.CFG_WE = 1'b0;
        check_eq("commit_last_vin", 32'(bus.F_VIN),    32'h1);
        check_eq("commit_last_din", 32'(bus.F_DIN),    32'h033);
        check_eq("commit_busy",     32'(bus.CFG_BUSY), 32'h1);
        stall = 0; rst_low = 0; early = 0;
        while (!bus.S_RDY && stall < 50) begin
            stall++;
            if (!bus.F_RST_n) rst_low++;
            if (bus.A1 != '0 || bus.B1 != '0 || bus.B0 != '0) early = 1;
            tick();
        end
        check_eq("drain_stall_cycles", 32'(stall),   32'd5);
        check_eq("drain_f_rst_low",    32'(rst_low), 32'd1);
        check_eq("drain_coef_early",   32'(early),   32'd0);
        check_eq("drain_a1",   32'(bus.A1),       32'h155);
        check_eq("drain_b1",   32'(bus.B1),       32'h0AA);
        check_eq("drain_b0",   32'(bus.B0),       32'h3FF);
        check_eq("drain_busy", 32'(bus.CFG_BUSY), 32'h0);
        check_eq("drain_err",  32'(bus.ERR),      32'h0);

        // Idle commit; last shadow write directly precedes the commit
        repeat (3) tick();
        cfg_write(ADDR_A1, 11'h012);
        cfg_write(ADDR_B1, 11'h034);
        cfg_write(ADDR_B0, 11'h056);
        check_eq("idle_pre_busy", 32'(bus.CFG_BUSY), 32'h0);
        cfg_write(ADDR_COMMIT, '0);
        bus.CFG_WE = 1'b0;
        check_eq("idle_t1_busy",  32'(bus.CFG_BUSY), 32'h1);
        check_eq("idle_t1_s_rdy", 32'(bus.S_RDY),    32'h0);
        check_eq("idle_t1_rst_n", 32'(bus.F_RST_n),  32'h1);
        tick();
        check_eq("idle_t2_busy",  32'(bus.CFG_BUSY), 32'h1);
        check_eq("idle_t2_rst_n", 32'(bus.F_RST_n),  32'h0);
        check_eq("idle_t2_a1",    32'(bus.A1),       32'h155);
        tick();
        check_eq("idle_t3_busy",  32'(bus.CFG_BUSY), 32'h0);
        check_eq("idle_t3_s_rdy", 32'(bus.S_RDY),    32'h1);
        check_eq("idle_t3_rst_n", 32'(bus.F_RST_n),  32'h1);
        check_eq("idle_t3_a1",    32'(bus.A1),       32'h012);
        check_eq("idle_t3_b1",    32'(bus.B1),       32'h034);
        check_eq("idle_t3_b0",    32'(bus.B0),       32'h056);
        check_eq("idle_t3_err",   32'(bus.ERR),      32'h0);

        // Shadow write during DRAIN is dropped and flags ERR
        cfg_write(ADDR_COMMIT, '0);
        cfg_write(ADDR_A1, 11'h7FF);
        bus.CFG_WE = 1'b0;
        check_eq("wr_drain_err",  32'(bus.ERR),      32'h1);
        check_eq("wr_drain_busy", 32'(bus.CFG_BUSY), 32'h1);
        tick();
        check_eq("wr_drain_a1",   32'(bus.A1),       32'h012);
        cfg_write(ADDR_COMMIT, '0);
        bus.CFG_WE = 1'b0;
        tick();
        tick();
        check_eq("wr_drain_a1_again", 32'(bus.A1), 32'h012);

        // Timeout: VOUT never returns
        rst = 1'b1;
        tick();
        check_eq("rst2_err", 32'(bus.ERR), 32'h0);
        check_eq("rst2_a1",  32'(bus.A1),  32'h0);
        rst = 1'b0;
        tick();
        cfg_write(ADDR_A1, 11'h2AB);
        bus.CFG_WE = 1'b0;
        vout_en   = 1'b0;
        bus.S_VIN = 1'b1;
        bus.S_DIN = 11'h0F0;
        cfg_write(ADDR_COMMIT, '0);
        bus.S_VIN  = 1'b0;
        bus.CFG_WE = 1'b0;
        busy = 0; early = 0;
        while (bus.CFG_BUSY && busy < 100) begin
            busy++;
            if (busy <= 16 && bus.ERR) early = 1;
            tick();
        end
        vout_en = 1'b1;
        check_eq("tmo_busy_cycles", 32'(busy),      32'd17);
        check_eq("tmo_err_early",   32'(early),     32'd0);
        check_eq("tmo_err",         32'(bus.ERR),   32'h1);
        check_eq("tmo_s_rdy",       32'(bus.S_RDY), 32'h1);
        check_eq("tmo_a1",          32'(bus.A1),    32'h2AB);

        // RST in the middle of DRAIN
        vout_en   = 1'b0;
        bus.S_VIN = 1'b1;
        bus.S_DIN = 11'h0A5;
        cfg_write(ADDR_COMMIT, '0);
        bus.S_VIN  = 1'b0;
        bus.CFG_WE = 1'b0;
        repeat (3) tick();
        check_eq("mid_drain_busy", 32'(bus.CFG_BUSY), 32'h1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_busy",  32'(bus.CFG_BUSY), 32'h0);
        check_eq("mid_rst_s_rdy", 32'(bus.S_RDY),    32'h0);
        check_eq("mid_rst_rst_n", 32'(bus.F_RST_n),  32'h0);
        check_eq("mid_rst_a1",    32'(bus.A1),       32'h0);
        check_eq("mid_rst_err",   32'(bus.ERR),      32'h0);
        check_eq("mid_rst_f_vin", 32'(bus.F_VIN),    32'h0);
        rst     = 1'b0;
        vout_en = 1'b1;
        tick();
        check_eq("post_rst_s_rdy", 32'(bus.S_RDY),    32'h1);
        check_eq("post_rst_rst_n", 32'(bus.F_RST_n),  32'h1);
        check_eq("post_rst_busy",  32'(bus.CFG_BUSY), 32'h0);

        // In-flight count restarts from zero after reset
        bus.S_VIN = 1'b1;
        bus.S_DIN = 11'h001;
        tick();
        tick();
        bus.S_VIN = 1'b0;
        repeat (5) tick();
        check_eq("post_rst_stream_err", 32'(bus.ERR), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
